// File: rtl/seg_pkg.sv
// Shared state encoding, segment lookup table and sizing helpers for the
// seven-segment scan controller.
package seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHOW,
      ST_BLANK
   } scan_state_e;

   // Active-low segments: bit7=a .. bit1=g, bit0=dp (kept off).
   localparam logic [7:0] HEX_SEG [16] = '{
      8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
      8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
      8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
      8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
   };

   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake carrying new display contents into the scan controller.
interface seg_scan_ctrl_if #(
   parameter int DIGITS = 8
);
   logic                  load_valid;
   logic                  load_ready;
   logic [4*DIGITS-1:0]   load_data;
   logic [DIGITS-1:0]     load_mask;

   modport master (
      output load_valid, load_data, load_mask,
      input  load_ready
   );

   modport slave (
      input  load_valid, load_data, load_mask,
      output load_ready
   );
endinterface

// File: rtl/seg_hex_dec.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_dec
   import seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [7:0] seg_o
);
   assign seg_o = HEX_SEG[nibble_i];
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scanner with SHOW/BLANK dwell per digit and a
// shadowed load that only takes effect at a frame boundary or while idle.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIGITS = 8,
   parameter int DIV    = 1000,
   parameter int BLANK  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   seg_scan_ctrl_if.slave    load_if,
   output logic [7:0]        seg_out_o,
   output logic [DIGITS-1:0] an_out_o
);
   localparam int CNT_W = clog2_min1(max_int(DIV, BLANK));
   localparam int IDX_W = clog2_min1(DIGITS);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

   scan_state_e           state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [4*DIGITS-1:0]   act_data_q, act_data_d, pend_data_q, pend_data_d;
   logic [DIGITS-1:0]     act_mask_q, act_mask_d, pend_mask_q, pend_mask_d;
   logic                  pending_q, pending_d;
   logic [7:0]            seg_q, seg_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic                  commit;
   logic                  accept;
   logic                  lit;
   logic [3:0]            nibble;
   logic [7:0]            hex_seg;

   seg_hex_dec u_hex_dec (
      .nibble_i (nibble),
      .seg_o    (hex_seg)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            commit = pending_q;
            idx_d  = '0;
            cnt_d  = '0;
            if (en_i) state_d = ST_SHOW;
         end
         ST_SHOW: begin
            if (!en_i) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == SHOW_LAST) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_BLANK: begin
            if (!en_i) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == BLANK_LAST) begin
               state_d = ST_SHOW;
               cnt_d   = '0;
               // Wrapping back to digit 0 is the frame boundary.
               if (idx_q == IDX_LAST) begin
                  idx_d  = '0;
                  commit = pending_q;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   assign load_if.load_ready = ~pending_q;
   assign accept = load_if.load_valid & ~pending_q;

   always_comb begin
      pend_data_d = pend_data_q;
      pend_mask_d = pend_mask_q;
      pending_d   = pending_q;
      act_data_d  = act_data_q;
      act_mask_d  = act_mask_q;
      if (accept) begin
         pend_data_d = load_if.load_data;
         pend_mask_d = load_if.load_mask;
         pending_d   = 1'b1;
      end else if (commit) begin
         act_data_d = pend_data_q;
         act_mask_d = pend_mask_q;
         pending_d  = 1'b0;
      end
   end

   // Outputs are decoded from next-state so they update on the same edge.
   always_comb begin
      lit    = (state_d == ST_SHOW) && act_mask_d[idx_d];
      nibble = act_data_d[int'(idx_d)*4 +: 4];
      seg_d  = lit ? hex_seg : 8'hFF;
      an_d   = lit ? ~(DIGITS'(1) << idx_d) : '1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         act_data_q  <= '0;
         act_mask_q  <= '0;
         pend_data_q <= '0;
         pend_mask_q <= '0;
         pending_q   <= 1'b0;
         seg_q       <= 8'hFF;
         an_q        <= '1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         act_data_q  <= act_data_d;
         act_mask_q  <= act_mask_d;
         pend_data_q <= pend_data_d;
         pend_mask_q <= pend_mask_d;
         pending_q   <= pending_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

   assign seg_out_o = seg_q;
   assign an_out_o  = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a frame-time model checked every cycle.
module tb_seg_scan_ctrl;
   localparam int DIGITS = 4;
   localparam int DIV    = 4;
   localparam int BLNK   = 2;
   localparam int SLOT   = DIV + BLNK;
   localparam int FRAME  = DIGITS * SLOT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic [7:0]        seg;
   logic [DIGITS-1:0] an;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] hexTab [16] = '{
      8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
      8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
      8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
      8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
   };

   seg_scan_ctrl_if #(.DIGITS(DIGITS)) loadIf ();

   seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLNK)) dut (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en),
      .load_if   (loadIf),
      .seg_out_o (seg),
      .an_out_o  (an)
   );

   always #5 clk = ~clk;

   // Model state: scan position as elapsed cycles within the frame.
   bit               mRunning = 1'b0;
   int               mT       = 0;
   bit               mPending = 1'b0;
   logic [15:0]      mActData = '0, mPendData = '0;
   logic [3:0]       mActMask = '0, mPendMask = '0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic enV, input logic validV,
                                input logic [15:0] dataV, input logic [3:0] maskV);
      en                = enV;
      loadIf.load_valid = validV;
      loadIf.load_data  = dataV;
      loadIf.load_mask  = maskV;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      bit          commit;
      bit          accept;
      bit          lit;
      int          digit;
      logic [7:0]  expSeg;
      logic [3:0]  expAn;
      forever begin
         @(posedge clk);
         if (rst) begin
            mRunning = 1'b0; mT = 0; mPending = 1'b0;
            mActData = '0; mActMask = '0; mPendData = '0; mPendMask = '0;
         end else begin
            commit = mPending && (!mRunning || (en && ((mT + 1) % FRAME == 0)));
            accept = loadIf.load_valid && !mPending;
            if (commit) begin
               mActData = mPendData;
               mActMask = mPendMask;
               mPending = 1'b0;
            end
            if (accept) begin
               mPendData = loadIf.load_data;
               mPendMask = loadIf.load_mask;
               mPending  = 1'b1;
            end
            if (!en) begin
               mRunning = 1'b0; mT = 0;
            end else if (!mRunning) begin
               mRunning = 1'b1; mT = 0;
            end else begin
               mT = (mT + 1) % FRAME;
            end
         end
         #1;
         if (!rst) begin
            digit  = mT / SLOT;
            lit    = mRunning && ((mT % SLOT) < DIV) && mActMask[digit];
            expSeg = lit ? hexTab[mActData[digit*4 +: 4]] : 8'hFF;
            expAn  = lit ? ~(4'b0001 << digit) : 4'hF;
            checkOutput("model_seg", 32'(seg), 32'(expSeg));
            checkOutput("model_an", 32'(an), 32'(expAn));
            checkOutput("model_ready", 32'(loadIf.load_ready), 32'(!mPending));
         end
      end
   end

   initial begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 4'h0);
      tick(3);
      rst = 1'b0;
      checkOutput("reset_seg", 32'(seg), 32'h0FF);
      checkOutput("reset_an", 32'(an), 32'hF);
      checkOutput("reset_ready", 32'(loadIf.load_ready), 32'h1);

      // Enabled with nothing loaded: everything stays dark.
      applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0);
      tick(30);
      checkOutput("noload_an", 32'(an), 32'hF);
      applyStimulus(1'b0, 1'b0, 16'h0000, 4'h0);
      tick(1);

      // Load while idle, then scan a full frame.
      applyStimulus(1'b0, 1'b1, 16'h3210, 4'hF);
      tick(1);
      checkOutput("idle_load_ready0", 32'(loadIf.load_ready), 32'h0);
      applyStimulus(1'b0, 1'b0, 16'h0000, 4'h0);
      tick(1);
      checkOutput("idle_commit_ready1", 32'(loadIf.load_ready), 32'h1);
      applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0);
      for (int k = 0; k <= 24; k++) begin
         tick(1);
         case (k)
            0:  begin checkOutput("f_k0_an", 32'(an), 32'hE); checkOutput("f_k0_seg", 32'(seg), 32'h03); end
            3:  checkOutput("f_k3_an", 32'(an), 32'hE);
            4:  begin checkOutput("f_k4_an", 32'(an), 32'hF); checkOutput("f_k4_seg", 32'(seg), 32'hFF); end
            6:  begin checkOutput("f_k6_an", 32'(an), 32'hD); checkOutput("f_k6_seg", 32'(seg), 32'h9F); end
            12: begin checkOutput("f_k12_an", 32'(an), 32'hB); checkOutput("f_k12_seg", 32'(seg), 32'h25); end
            18: begin checkOutput("f_k18_an", 32'(an), 32'h7); checkOutput("f_k18_seg", 32'(seg), 32'h0D); end
            23: checkOutput("f_k23_an", 32'(an), 32'hF);
            24: begin checkOutput("f_k24_an", 32'(an), 32'hE); checkOutput("f_k24_seg", 32'(seg), 32'h03); end
            default: ;
         endcase
      end

      // Mid-frame load during digit 1 waits for the frame boundary.
      tick(6);
      applyStimulus(1'b1, 1'b1, 16'hFEDC, 4'hF);
      tick(1);
      checkOutput("mid_ready0", 32'(loadIf.load_ready), 32'h0);
      checkOutput("mid_d1_old", 32'(seg), 32'h9F);
      applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0);
      tick(5);
      checkOutput("mid_d2_old_seg", 32'(seg), 32'h25);
      checkOutput("mid_d2_ready0", 32'(loadIf.load_ready), 32'h0);
      tick(11);
      checkOutput("mid_t23_ready0", 32'(loadIf.load_ready), 32'h0);
      tick(1);
      checkOutput("mid_d0_new_seg", 32'(seg), 32'h63);
      checkOutput("mid_d0_new_an", 32'(an), 32'hE);
      checkOutput("mid_after_ready1", 32'(loadIf.load_ready), 32'h1);

      // Sparse mask: digits 1 and 3 stay dark with unchanged timing.
      applyStimulus(1'b1, 1'b1, 16'h3210, 4'b0101);
      tick(1);
      checkOutput("mask_pre_seg", 32'(seg), 32'h63);
      applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0);
      tick(23);
      checkOutput("mask_d0_an", 32'(an), 32'hE);
      checkOutput("mask_d0_seg", 32'(seg), 32'h03);
      tick(6);
      checkOutput("mask_d1_an", 32'(an), 32'hF);
      checkOutput("mask_d1_seg", 32'(seg), 32'hFF);
      tick(6);
      checkOutput("mask_d2_an", 32'(an), 32'hB);
      tick(6);
      checkOutput("mask_d3_an", 32'(an), 32'hF);

      // Drop enable during digit 2 and restart.
      tick(19);
      checkOutput("en_d2_an", 32'(an), 32'hB);
      applyStimulus(1'b0, 1'b0, 16'h0000, 4'h0);
      tick(1);
      checkOutput("en_off_an", 32'(an), 32'hF);
      checkOutput("en_off_seg", 32'(seg), 32'hFF);
      tick(3);
      applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0);
      tick(1);
      checkOutput("restart_an", 32'(an), 32'hE);
      checkOutput("restart_seg", 32'(seg), 32'h03);
      tick(3);
      checkOutput("restart_k3_an", 32'(an), 32'hE);
      tick(1);
      checkOutput("restart_k4_an", 32'(an), 32'hF);

      // Reset mid-SHOW with a pending load.
      applyStimulus(1'b1, 1'b1, 16'hFFFF, 4'hF);
      tick(1);
      checkOutput("rst_pend_ready0", 32'(loadIf.load_ready), 32'h0);
      applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0);
      tick(7);
      checkOutput("rst_pre_an", 32'(an), 32'hB);
      checkOutput("rst_pre_seg", 32'(seg), 32'h25);
      #1 rst = 1'b1;
      #1;
      checkOutput("rst_async_an", 32'(an), 32'hF);
      checkOutput("rst_async_seg", 32'(seg), 32'hFF);
      checkOutput("rst_async_ready", 32'(loadIf.load_ready), 32'h1);
      tick(1);
      rst = 1'b0;
      checkOutput("rst_rel_ready", 32'(loadIf.load_ready), 32'h1);
      tick(1);
      checkOutput("rst_d0_dark", 32'(an), 32'hF);
      tick(12);
      checkOutput("rst_d2_dark", 32'(an), 32'hF);
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 8: number of time-multiplexed 7-segment digits.
REQ-002 Parameter DIV, default 1000: SHOW dwell per digit in clk cycles, minimum 1.
REQ-003 Parameter BLANK, default 4: anti-ghost blank cycles between digits, minimum 1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  scan enable; 0 forces IDLE.
REQ-007 load_valid  input  1  new display contents offered.
REQ-008 load_ready  output  1  controller can accept a load.
REQ-009 load_data  input  4*DIGITS  hex nibbles; nibble k, bits [4k+3:4k], drives digit k.
REQ-010 load_mask  input  DIGITS  bit k=1 enables digit k.
REQ-011 seg_out  output  8  active-low segments: bit7=a .. bit1=g, bit0=dp, dp always 1 (off).
REQ-012 an_out  output  DIGITS  active-low digit selects, at most one bit low at a time.

Function
REQ-013 Load handshake SHALL complete on a clk edge with load_valid=1 and load_ready=1, capturing data and mask into a pending shadow; load_ready = !pending.
REQ-014 Pending contents SHALL commit to the active registers, clearing pending, at a frame boundary: the BLANK->SHOW transition from digit DIGITS-1 to digit 0, or any cycle in IDLE.
REQ-015 No handshake SHALL complete while pending=1; load_ready is 0 for the commit cycle and returns to 1 the cycle after.
REQ-016 FSM states: IDLE, SHOW, BLANK; IDLE->SHOW(digit 0) when en=1; SHOW->BLANK after exactly DIV cycles; BLANK->SHOW(next digit) after exactly BLANK cycles.
REQ-017 The next digit SHALL be idx+1, wrapping DIGITS-1 -> 0; frame period = DIGITS*(DIV+BLANK) cycles.
REQ-018 en=0 in any state SHALL move to IDLE on the next edge, reset digit index to 0 and clear the dwell counter; restart always begins at digit 0 with a full DIV dwell.
REQ-019 SHOW with active mask bit idx=1 SHALL drive an_out bit idx low and seg_out to the hex code of active nibble idx.
REQ-020 SHOW with mask bit 0, BLANK, and IDLE SHALL drive an_out all 1s and seg_out 8'hFF.
REQ-021 Hex codes (seg_out): 0=00000011 1=10011111 2=00100101 3=00001101 4=10011001 5=01001001 6=01000001 7=00011111 8=00000001 9=00001001 A=00010001 b=11000001 C=01100011 d=10000101 E=01100001 F=01110001.
REQ-022 seg_out and an_out SHALL be registered: both change on the same edge as the state change that causes them, glitch-free.
REQ-023 The dwell counter SHALL be sized clog2(max(DIV,BLANK)) bits and the digit index clog2(DIGITS) bits, minimum 1 bit each.

Reset
REQ-024 While rst=1: state IDLE, digit index 0, dwell counter 0, active data 0, active mask 0, pending 0, load_ready 1, seg_out 8'hFF, an_out all 1s.
REQ-025 rst asserted mid-SHOW SHALL blank outputs immediately (asynchronously) and discard any pending load.

Structure
REQ-026 Shared package seg_pkg SHALL hold the state encoding (IDLE/SHOW/BLANK) and the 16-entry hex-to-segment constant table.
REQ-027 Hex decoding SHALL sit in one combinational sub-module, seg_hex_dec (4-bit in, 8-bit active-low out), feeding the output register.

Verification (DIGITS=4, DIV=4, BLANK=2 unless stated)
REQ-028 Reset release, en=1, no load -> every cycle an_out=4'hF, seg_out=8'hFF (mask 0).
REQ-029 In IDLE, load data=16'h3210, mask=4'hF -> committed next cycle; with en=1, an_out sequence 1110,1101,1011,0111, each 4 cycles, separated by 2 cycles of 1111; seg_out 00000011, 10011111, 00100101, 00001101; 24-cycle period.
REQ-030 Mid-frame load 16'hFEDC at digit 1 -> load_ready 0 until the digit3->digit0 boundary; digit 2 still shows old nibble; digit 0 then shows 01100011 (C).
REQ-031 Mask 4'b0101 -> an_out low only for digits 0 and 2; digits 1 and 3 slots all-blank while timing is unchanged.
REQ-032 en dropped during digit 2 SHOW -> next cycle all outputs off; en re-asserted -> digit 0 shows for a full 4 cycles.
REQ-033 rst pulse mid-SHOW with a pending load -> outputs blank without a clk edge; after release load_ready=1 and active mask=0.
